// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default baud divisor, parity modes.
package uart_pkg;

  // Line-state encoding shared by receiver and transmitter.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_t;

  // 50 MHz system clock at 115200 baud.
  localparam int UART_CLKS_PER_BIT = 434;

  // Parity modes.
  localparam bit UART_PARITY_EVEN = 1'b0;
  localparam bit UART_PARITY_ODD  = 1'b1;

  // True when data bits plus received parity bit do not give the wanted parity.
  // Narrower data words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_mismatch(input logic [7:0] data,
                                           input logic       par_bit,
                                           input logic       odd);
    return ((^data) ^ par_bit) != odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset value so an idle-high line does not look like a start bit.
module rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic asyncreset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture to settle metastability before the FSM sees the line.
  always_ff @(posedge clk or posedge asyncreset) begin
    if (asyncreset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of an async serial line, parallel hold
// register with valid/read handshake, framing/parity/overrun pulses.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | line idle, counter held at 0, waiting for a low level
// ST_START  | confirming start bit at half a bit time; high = glitch
// ST_DATA   | sampling DATA_BITS data bits, LSB first, at full bit time
// ST_PARITY | sampling parity bit; mismatch latched until completion
// ST_STOP   | sampling stop bit; high = frame done, low = framing error
// ST_BREAK  | line held low after a bad stop bit; wait for it to go high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 asyncreset,
  input  logic                 rx_serial,
  input  logic                 rx_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  logic                 rxs;
  uart_state_t          state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 done;

  rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk        (clk),
    .asyncreset (asyncreset),
    .d          (rx_serial),
    .q          (rxs)
  );

  // Frame FSM plus the hold register; completion is handled one cycle after
  // the good stop-bit sample so shreg and par_bad are already settled.
  always_ff @(posedge clk or posedge asyncreset) begin
    if (asyncreset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      done       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      done       <= 1'b0;

      // Hold-register update. A read in the same cycle as a good completion
      // frees the register, so the new byte loads instead of overrunning.
      if (done) begin
        if (par_bad) begin
          parity_err <= 1'b1;
          if (rx_read) begin
            rx_valid <= 1'b0;
          end
        end else if (rx_valid && !rx_read) begin
          overrun <= 1'b1;
        end else begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end
      end else if (rx_read) begin
        rx_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            state <= ST_START;
          end
        end

        ST_START: begin
          if (cnt == HALF_CNT) begin
            cnt <= '0;
            if (!rxs) begin
              state   <= ST_DATA;
              bit_idx <= '0;
              par_bad <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (cnt == FULL_CNT) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_IDX) begin
              bit_idx <= '0;
              state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_PARITY: begin
          if (cnt == FULL_CNT) begin
            cnt     <= '0;
            par_bad <= parity_mismatch(8'(shreg), rxs, PARITY_ODD != 0);
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (cnt == FULL_CNT) begin
            cnt <= '0;
            if (rxs) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_BREAK: begin
          cnt <= '0;
          if (rxs) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: an 8N1 instance and an even-parity instance
// at 16 clocks per bit, directed scenarios plus randomized frames.
module tb_uart_rx;

  localparam int CLKS = 16;
  // Stop-bit sample edge, counted in clocks from the cycle in which the bench
  // drops the line (line falls half a clock before the next edge): 1 to reach
  // that edge, 2 synchronizer cycles, then 9.5 bit times (10.5 with parity).
  localparam int SAMPLE_OFF_8 = 1 + 2 + 10 * CLKS - CLKS / 2;
  localparam int SAMPLE_OFF_P = 1 + 2 + 11 * CLKS - CLKS / 2;

  logic       clk = 1'b0;
  logic       asyncreset = 1'b1;
  logic       rx8 = 1'b1, rxp = 1'b1;
  logic       rd8 = 1'b0, rdp = 1'b0;
  logic [7:0] data8, datap;
  logic       valid8, validp, fe8, fep, pe8, pep, ov8, ovp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_n8 = 0, pe_n8 = 0, ov_n8 = 0, fe_np = 0, pe_np = 0, ov_np = 0;
  int rise8 = -1, risep = -1;
  logic v8_d = 1'b0, vp_d = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut8 (
    .clk(clk), .asyncreset(asyncreset), .rx_serial(rx8), .rx_read(rd8),
    .rx_data(data8), .rx_valid(valid8), .frame_err(fe8), .parity_err(pe8), .overrun(ov8));

  uart_rx #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dutp (
    .clk(clk), .asyncreset(asyncreset), .rx_serial(rxp), .rx_read(rdp),
    .rx_data(datap), .rx_valid(validp), .frame_err(fep), .parity_err(pep), .overrun(ovp));

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and rx_valid rise times, sampled mid-cycle.
  always @(negedge clk) begin
    if (fe8) fe_n8++;
    if (pe8) pe_n8++;
    if (ov8) ov_n8++;
    if (fep) fe_np++;
    if (pep) pe_np++;
    if (ovp) ov_np++;
    if (valid8 && !v8_d) rise8 = cyc;
    if (validp && !vp_d) risep = cyc;
    v8_d = valid8;
    vp_d = validp;
  end

  // Drives one frame starting at a falling clock edge; optionally pulses the
  // read strobe so it is high on the completion cycle.
  task automatic send_frame(input bit use_par, input logic [7:0] d, input logic par_bit,
                            input logic stop_bit, input bit read_at_done, output int c0);
    logic [10:0] bits;
    int nb, soff;
    bits = use_par ? {stop_bit, par_bit, d, 1'b0} : {1'b0, stop_bit, d, 1'b0};
    nb   = use_par ? 11 : 10;
    soff = use_par ? SAMPLE_OFF_P : SAMPLE_OFF_8;
    c0   = cyc;
    for (int t = 0; t < nb * CLKS; t++) begin
      if (use_par) begin
        rxp = bits[t / CLKS];
        rdp = read_at_done && (t == soff);
      end else begin
        rx8 = bits[t / CLKS];
        rd8 = read_at_done && (t == soff);
      end
      @(negedge clk);
    end
    rd8 = 1'b0;
    rdp = 1'b0;
  endtask

  task automatic read8();
    rd8 = 1'b1;
    @(negedge clk);
    rd8 = 1'b0;
  endtask

  task automatic readp();
    rdp = 1'b1;
    @(negedge clk);
    rdp = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (data8 !== 8'h00 || valid8 !== 1'b0) begin errors++;
      $display("FAIL reset_8: data=%h valid=%b, expected 00/0", data8, valid8); end
    checks++; if ({fe8, pe8, ov8} !== 3'b000) begin errors++;
      $display("FAIL reset_8_flags: fe/pe/ov=%b, expected 000", {fe8, pe8, ov8}); end
    checks++; if (datap !== 8'h00 || validp !== 1'b0 || {fep, pep, ovp} !== 3'b000) begin errors++;
      $display("FAIL reset_p: data=%h valid=%b flags=%b, expected 00/0/000", datap, validp, {fep, pep, ovp}); end
    repeat (3) @(negedge clk);
    asyncreset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int c0, fe0, pe0, ov0;
    fe0 = fe_n8; pe0 = pe_n8; ov0 = ov_n8; rise8 = -1;
    send_frame(0, 8'hA5, 1'b0, 1'b1, 0, c0);
    repeat (2) @(negedge clk);
    checks++; if (data8 !== 8'hA5 || valid8 !== 1'b1) begin errors++;
      $display("FAIL good_data: data=%h valid=%b, expected a5/1", data8, valid8); end
    checks++; if (rise8 != c0 + SAMPLE_OFF_8 + 1) begin errors++;
      $display("FAIL good_latency: valid rose at cycle %0d, expected %0d", rise8, c0 + SAMPLE_OFF_8 + 1); end
    checks++; if (fe_n8 != fe0 || pe_n8 != pe0 || ov_n8 != ov0) begin errors++;
      $display("FAIL good_flags: fe/pe/ov pulses %0d/%0d/%0d, expected 0/0/0", fe_n8 - fe0, pe_n8 - pe0, ov_n8 - ov0); end
    read8();
    checks++; if (valid8 !== 1'b0 || data8 !== 8'hA5) begin errors++;
      $display("FAIL good_read: valid=%b data=%h, expected 0/a5", valid8, data8); end
  endtask

  task automatic test_glitch();
    int c0, fe0;
    fe0 = fe_n8; rise8 = -1;
    rx8 = 1'b0;
    repeat (5) @(negedge clk);
    rx8 = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (valid8 !== 1'b0 || rise8 != -1 || fe_n8 != fe0) begin errors++;
      $display("FAIL glitch_ignored: valid=%b rise=%0d fe_pulses=%0d, expected 0/-1/0", valid8, rise8, fe_n8 - fe0); end
    send_frame(0, 8'h3C, 1'b0, 1'b1, 0, c0);
    repeat (2) @(negedge clk);
    checks++; if (data8 !== 8'h3C || valid8 !== 1'b1) begin errors++;
      $display("FAIL glitch_next: data=%h valid=%b, expected 3c/1", data8, valid8); end
    read8();
  endtask

  task automatic test_framing();
    int c0, fe0;
    fe0 = fe_n8; rise8 = -1;
    send_frame(0, 8'h55, 1'b0, 1'b0, 0, c0);
    repeat (40) @(negedge clk);
    rx8 = 1'b1;
    repeat (3 * CLKS) @(negedge clk);
    checks++; if (fe_n8 - fe0 != 1) begin errors++;
      $display("FAIL frame_pulse: %0d frame_err pulses, expected 1", fe_n8 - fe0); end
    checks++; if (valid8 !== 1'b0 || rise8 != -1 || data8 !== 8'h3C) begin errors++;
      $display("FAIL frame_hold: valid=%b rise=%0d data=%h, expected 0/-1/3c", valid8, rise8, data8); end
    send_frame(0, 8'h0F, 1'b0, 1'b1, 0, c0);
    repeat (2) @(negedge clk);
    checks++; if (data8 !== 8'h0F || valid8 !== 1'b1) begin errors++;
      $display("FAIL frame_next: data=%h valid=%b, expected 0f/1", data8, valid8); end
    read8();
  endtask

  task automatic test_overrun();
    int c0, ov0;
    send_frame(0, 8'h11, 1'b0, 1'b1, 0, c0);
    repeat (2) @(negedge clk);
    ov0 = ov_n8;
    send_frame(0, 8'h22, 1'b0, 1'b1, 0, c0);
    repeat (2) @(negedge clk);
    checks++; if (ov_n8 - ov0 != 1) begin errors++;
      $display("FAIL overrun_pulse: %0d overrun pulses, expected 1", ov_n8 - ov0); end
    checks++; if (data8 !== 8'h11 || valid8 !== 1'b1) begin errors++;
      $display("FAIL overrun_keep: data=%h valid=%b, expected 11/1", data8, valid8); end
    ov0 = ov_n8;
    send_frame(0, 8'h22, 1'b0, 1'b1, 1, c0);
    repeat (2) @(negedge clk);
    checks++; if (data8 !== 8'h22 || valid8 !== 1'b1 || ov_n8 != ov0) begin errors++;
      $display("FAIL same_cycle_read: data=%h valid=%b overruns=%0d, expected 22/1/0", data8, valid8, ov_n8 - ov0); end
    read8();
  endtask

  task automatic test_parity();
    int c0, pe0, ov0;
    pe0 = pe_np; risep = -1;
    send_frame(1, 8'h07, 1'b1, 1'b1, 0, c0);
    repeat (2) @(negedge clk);
    checks++; if (datap !== 8'h07 || validp !== 1'b1 || pe_np != pe0) begin errors++;
      $display("FAIL parity_good: data=%h valid=%b pe_pulses=%0d, expected 07/1/0", datap, validp, pe_np - pe0); end
    checks++; if (risep != c0 + SAMPLE_OFF_P + 1) begin errors++;
      $display("FAIL parity_latency: valid rose at cycle %0d, expected %0d", risep, c0 + SAMPLE_OFF_P + 1); end
    pe0 = pe_np; ov0 = ov_np;
    send_frame(1, 8'h07, 1'b0, 1'b1, 0, c0);
    repeat (2) @(negedge clk);
    checks++; if (pe_np - pe0 != 1 || ov_np != ov0) begin errors++;
      $display("FAIL parity_bad_pulse: pe=%0d ov=%0d pulses, expected 1/0", pe_np - pe0, ov_np - ov0); end
    checks++; if (datap !== 8'h07 || validp !== 1'b1) begin errors++;
      $display("FAIL parity_bad_hold: data=%h valid=%b, expected 07/1", datap, validp); end
    readp();
  endtask

  // Reference: a good frame either lands in the hold register or, if an
  // unread byte is still there and no read coincides, is dropped as overrun.
  task automatic test_random8();
    int c0, ov0, mode;
    logic [7:0] b, exp_data;
    logic exp_valid;
    bit exp_ov;
    exp_valid = 1'b0; exp_data = 8'h00;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      mode = (i == 0) ? 1 : int'($urandom_range(0, 2));
      if (mode == 1) begin read8(); exp_valid = 1'b0; end
      ov0 = ov_n8;
      send_frame(0, b, 1'b0, 1'b1, mode == 2, c0);
      repeat (3) @(negedge clk);
      if (exp_valid && mode != 2) exp_ov = 1'b1;
      else begin exp_ov = 1'b0; exp_data = b; exp_valid = 1'b1; end
      checks++; if (data8 !== exp_data || valid8 !== exp_valid || (ov_n8 - ov0) != int'(exp_ov)) begin errors++;
        $display("FAIL random8[%0d]: data=%h valid=%b ov=%0d, expected %h/%b/%0d", i, data8, valid8, ov_n8 - ov0, exp_data, exp_valid, exp_ov); end
    end
    read8();
  endtask

  task automatic test_random_parity();
    int c0, pe0;
    logic [7:0] b, exp_data;
    logic par;
    bit good;
    exp_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      good = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      par = ^b;
      if (!good) par = ~par;
      readp();
      pe0 = pe_np;
      send_frame(1, b, par, 1'b1, 0, c0);
      repeat (3) @(negedge clk);
      if (good) exp_data = b;
      checks++; if (datap !== exp_data || validp !== good || (pe_np - pe0) != int'(!good)) begin errors++;
        $display("FAIL random_parity[%0d]: data=%h valid=%b pe=%0d, expected %h/%b/%0d", i, datap, validp, pe_np - pe0, exp_data, good, !good); end
    end
    // Leave a byte pending in the parity instance so the reset has something to clear.
    send_frame(1, 8'h96, 1'b0, 1'b1, 0, c0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int c0, fe0;
    send_frame(0, 8'h5A, 1'b0, 1'b1, 0, c0);
    repeat (2) @(negedge clk);
    checks++; if (valid8 !== 1'b1 || validp !== 1'b1) begin errors++;
      $display("FAIL pre_reset_pending: valid8=%b validp=%b, expected 1/1", valid8, validp); end
    // Start bit plus data bits 0..3 of 0xFF, then halfway into bit 4.
    for (int t = 0; t < 5 * CLKS + CLKS / 2; t++) begin
      rx8 = (t < CLKS) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    #2 asyncreset = 1'b1;
    #1;
    checks++; if (data8 !== 8'h00 || valid8 !== 1'b0 || {fe8, pe8, ov8} !== 3'b000) begin errors++;
      $display("FAIL reset_mid_8: data=%h valid=%b flags=%b, expected 00/0/000", data8, valid8, {fe8, pe8, ov8}); end
    checks++; if (datap !== 8'h00 || validp !== 1'b0) begin errors++;
      $display("FAIL reset_mid_p: data=%h valid=%b, expected 00/0", datap, validp); end
    rx8 = 1'b1;
    repeat (3) @(negedge clk);
    asyncreset = 1'b0;
    repeat (4) @(negedge clk);
    fe0 = fe_n8; rise8 = -1;
    send_frame(0, 8'h81, 1'b0, 1'b1, 0, c0);
    repeat (2) @(negedge clk);
    checks++; if (data8 !== 8'h81 || valid8 !== 1'b1 || fe_n8 != fe0) begin errors++;
      $display("FAIL reset_after: data=%h valid=%b fe=%0d, expected 81/1/0", data8, valid8, fe_n8 - fe0); end
    checks++; if (rise8 != c0 + SAMPLE_OFF_8 + 1) begin errors++;
      $display("FAIL reset_after_latency: valid rose at cycle %0d, expected %0d", rise8, c0 + SAMPLE_OFF_8 + 1); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_framing();
    test_overrun();
    test_parity();
    test_random8();
    test_random_parity();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
